regfile_seq: RTL

Command sequencer driving the write/read ports of the 8×16 register file. It accepts one register-transfer command at a time over a valid/ready handshake. It reads source operands through the file's single read port, computes a 16-bit result, and writes it back through the write port. It is the initiator side of the register file interface and sits between instruction control and the regfile in the lab datapath.

---
 rtl/regfile_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_seq.sv
// Command sequencer for the 8x16 register file: reads up to two source
// operands through the single read port, then writes one 16-bit result back.
module regfile_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic [15:0] cmd_imm,
  output logic [2:0]  readnum,
  input  logic [15:0] data_out,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [15:0] data_in,
  output logic        done,
  output logic        zero,
  output logic [1:0]  dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, nothing is queued.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READA = 2'd1,
    S_READB = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [2:0]  r_rd;
  logic [2:0]  r_rs1;
  logic [2:0]  r_rs2;
  logic [15:0] r_imm;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_done;
  logic        r_zero;
  logic [15:0] w_result;

  always_comb begin
    w_result = r_imm;
    case (r_op)
      OP_MOVI: w_result = r_imm;
      OP_MOV:  w_result = r_a;
      OP_ADD:  w_result = r_a + r_b;
      default: w_result = r_a & r_b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_rd    <= 3'd0;
      r_rs1   <= 3'd0;
      r_rs2   <= 3'd0;
      r_imm   <= 16'd0;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_rd    <= cmd_rd;
            r_rs1   <= cmd_rs1;
            r_rs2   <= cmd_rs2;
            r_imm   <= cmd_imm;
            r_state <= (cmd_op == OP_MOVI) ? S_WRITE : S_READA;
          end
        end
        S_READA: begin
          r_a     <= data_out;
          r_state <= (r_op == OP_MOV) ? S_WRITE : S_READB;
        end
        S_READB: begin
          r_b     <= data_out;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_zero  <= (w_result == 16'd0);
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Port outputs decode the state register, so reset clears them at once.
  assign cmd_ready = (r_state == S_IDLE);
  assign readnum   = (r_state == S_READA) ? r_rs1 :
                     (r_state == S_READB) ? r_rs2 : 3'd0;
  assign write     = (r_state == S_WRITE);
  assign writenum  = (r_state == S_WRITE) ? r_rd : 3'd0;
  assign data_in   = (r_state == S_WRITE) ? w_result : 16'd0;
  assign done      = r_done;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule
